// File: rtl/game_pkg.sv
// Shared game types: the 2-bit state seen by frog and renderer, plus scoring constants.
package game_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } state_t;

    localparam int unsigned SCORE_BASE = 10;

endpackage

// File: rtl/game_ctrl_sec_tick_gen.sv
// Divides frame_tick down to a one-cycle sec_tick; clear restarts the second.
module sec_tick_gen #(
    parameter int unsigned FRAMES_PER_SEC = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic frame_tick,
    output logic sec_tick
);

    localparam int unsigned CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_SEC - 1);

    logic [CW-1:0] count;

    // Combinational so the timer steps on the same edge as the wrapping frame
    assign sec_tick = enable && !clear && frame_tick && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && frame_tick) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game FSM: lives, countdown timer, crossings, score and frog respawn pulses.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned TIME_LIMIT     = 30,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned CROSSINGS_WIN  = 5,
    parameter int unsigned GUARD_FRAMES   = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_tick,
    input  logic        frame_tick,
    input  logic        collision,
    input  logic        reached_end,
    output logic [1:0]  state,
    output logic        frog_reset,
    output logic [2:0]  lives,
    output logic [5:0]  timer,
    output logic [3:0]  crossings,
    output logic [15:0] score
);

    localparam int unsigned GW = $clog2(GUARD_FRAMES + 1);

    state_t        st;
    logic [GW-1:0] guard;
    logic          sec_tick;
    logic          playing;
    logic          new_game;
    logic          ev_end;
    logic          ev_die;
    logic          respawn;
    logic [3:0]    next_cross;
    logic [16:0]   sum;

    assign state = st;

    always_comb begin
        playing    = (st == PLAYING);
        new_game   = (st == MENU) && start_tick;
        ev_end     = playing && (guard == '0) && reached_end;
        ev_die     = playing && (guard == '0) && !reached_end
                     && (collision || timer == 6'd0);
        next_cross = crossings + 4'd1;
        respawn    = (ev_end && next_cross != 4'(CROSSINGS_WIN))
                     || (ev_die && lives > 3'd1);
        sum        = {1'b0, score} + 17'(SCORE_BASE) + 17'(timer);
    end

    sec_tick_gen #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_sec (
        .clk       (clk),
        .reset     (reset),
        .enable    (playing),
        .clear     (respawn || new_game),
        .frame_tick(frame_tick),
        .sec_tick  (sec_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= MENU;
            frog_reset <= 1'b1;
            lives      <= 3'(LIVES_INIT);
            timer      <= 6'(TIME_LIMIT);
            crossings  <= '0;
            score      <= '0;
            guard      <= '0;
        end else begin
            frog_reset <= 1'b0;
            unique case (st)
                MENU: begin
                    if (start_tick) begin
                        st         <= PLAYING;
                        frog_reset <= 1'b1;
                        lives      <= 3'(LIVES_INIT);
                        timer      <= 6'(TIME_LIMIT);
                        crossings  <= '0;
                        score      <= '0;
                        guard      <= GW'(GUARD_FRAMES);
                    end
                end
                PLAYING: begin
                    if (frame_tick && guard != '0)
                        guard <= guard - GW'(1);
                    if (sec_tick && timer != 6'd0)
                        timer <= timer - 6'd1;
                    if (ev_end) begin
                        crossings <= next_cross;
                        score     <= sum[16] ? 16'hFFFF : sum[15:0];
                        if (next_cross == 4'(CROSSINGS_WIN))
                            st <= WIN;
                    end else if (ev_die) begin
                        if (lives <= 3'd1) begin
                            lives <= 3'd0;
                            st    <= DEAD;
                        end else begin
                            lives <= lives - 3'd1;
                        end
                    end
                    // Reload placed last so it overrides any same-cycle decrement
                    if (respawn) begin
                        frog_reset <= 1'b1;
                        timer      <= 6'(TIME_LIMIT);
                        guard      <= GW'(GUARD_FRAMES);
                    end
                end
                DEAD, WIN: begin
                    if (start_tick)
                        st <= MENU;
                end
                default: st <= MENU;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with small parameters and hand-computed expectations.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_tick = 1'b0;
    logic        frame_tick = 1'b0;
    logic        collision = 1'b0;
    logic        reached_end = 1'b0;
    logic [1:0]  state;
    logic        frog_reset;
    logic [2:0]  lives;
    logic [5:0]  timer;
    logic [3:0]  crossings;
    logic [15:0] score;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .LIVES_INIT    (2),
        .TIME_LIMIT    (3),
        .FRAMES_PER_SEC(2),
        .CROSSINGS_WIN (2),
        .GUARD_FRAMES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_tick (start_tick),
        .frame_tick (frame_tick),
        .collision  (collision),
        .reached_end(reached_end),
        .state      (state),
        .frog_reset (frog_reset),
        .lives      (lives),
        .timer      (timer),
        .crossings  (crossings),
        .score      (score)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start_tick = 1'b1;
        step();
        start_tick = 1'b0;
    endtask

    initial begin
        #2;
        // 1: reset and new game
        reset = 1'b1;
        step();
        check("rst_state", state, 0);
        check("rst_frog", frog_reset, 1);
        check("rst_lives", lives, 2);
        check("rst_timer", timer, 3);
        reset = 1'b0;
        step();
        check("idle_frog", frog_reset, 0);
        pulse_start();
        check("go_state", state, 1);
        check("go_frog", frog_reset, 1);
        check("go_lives", lives, 2);
        check("go_timer", timer, 3);
        check("go_score", score, 0);
        step();
        check("go_frog_off", frog_reset, 0);

        // 2: collision during guard ignored, timer counting
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("guard_lives", lives, 2);
        check("guard_state", state, 1);
        frames(2);
        check("t_after2", timer, 2);

        // 3: crossings and win
        reached_end = 1'b1;
        step();
        reached_end = 1'b0;
        check("x1_cross", crossings, 1);
        check("x1_score", score, 12);
        check("x1_frog", frog_reset, 1);
        check("x1_timer", timer, 3);
        frames(4);
        check("t_after4", timer, 1);
        check("x1_frog_off", frog_reset, 0);
        reached_end = 1'b1;
        step();
        reached_end = 1'b0;
        check("win_state", state, 3);
        check("win_cross", crossings, 2);
        check("win_score", score, 23);
        check("win_frog", frog_reset, 0);
        pulse_start();
        check("win_menu", state, 0);

        // 4: two collisions -> dead
        pulse_start();
        check("ng_score", score, 0);
        check("ng_cross", crossings, 0);
        frames(2);
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("c1_lives", lives, 1);
        check("c1_frog", frog_reset, 1);
        check("c1_timer", timer, 3);
        frames(2);
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("c2_lives", lives, 0);
        check("c2_state", state, 2);
        check("c2_frog", frog_reset, 0);
        step();
        check("dead_hold", state, 2);
        pulse_start();
        check("dead_menu", state, 0);

        // 5: timeout death, then simultaneous reached_end/collision
        pulse_start();
        frames(6);
        check("to_timer0", timer, 0);
        check("to_lives_pre", lives, 2);
        step();
        check("to_lives", lives, 1);
        check("to_frog", frog_reset, 1);
        check("to_timer", timer, 3);
        frames(2);
        reached_end = 1'b1;
        collision = 1'b1;
        step();
        reached_end = 1'b0;
        collision = 1'b0;
        check("both_cross", crossings, 1);
        check("both_lives", lives, 1);
        check("both_score", score, 12);

        // 6: reset mid-game
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_state", state, 0);
        check("mr_score", score, 0);
        check("mr_lives", lives, 2);
        check("mr_cross", crossings, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
